// File: rtl/dmem_sram_bridge_pkg.sv
// Shared encodings for the data-side SRAM bridge: FSM states, access sizes and
// the kseg0/kseg1 window test also used by the instruction-side bridge.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // kseg0 (100) and kseg1 (101) share the top two address bits 2'b10.
  function automatic logic is_kseg01(input logic [1:0] i_top2);
    return i_top2 == 2'b10;
  endfunction

endpackage

// File: rtl/dmem_sram_bridge_kseg_addr_map.sv
// Combinational virtual-to-physical mapping: kseg0/kseg1 lose their top 3 bits
// when MAP_KSEG is set, every other address passes through unchanged.
module kseg_addr_map
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic [ADDR_W-1:0] i_vaddr,
  output logic [ADDR_W-1:0] o_paddr
);

  logic w_hit;

  assign w_hit   = MAP_KSEG && is_kseg01(i_vaddr[ADDR_W-1 -: 2]);
  assign o_paddr = w_hit ? {3'b000, i_vaddr[ADDR_W-4:0]} : i_vaddr;

endmodule

// File: rtl/dmem_sram_bridge.sv
// MEM-stage to SRAM-like bus bridge: one bus transaction per memory instruction,
// pipeline stalled from issue to data_ok (2 cycles minimum), load word held until the pipeline advances.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_except_i,
  input  logic              flush_i,
  input  logic              other_stall_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [3:0]        data_wstrb_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  state_e             r_state;
  logic               r_wr;
  logic [1:0]         r_size;
  logic [3:0]         r_wstrb;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_drop;

  logic               w_start;
  logic               w_drop_now;
  logic [ADDR_W-1:0]  w_paddr;

  assign w_start    = mem_en_i & ~mem_except_i & ~flush_i;
  assign w_drop_now = r_drop | flush_i;

  kseg_addr_map #(
    .ADDR_W   (ADDR_W),
    .MAP_KSEG (MAP_KSEG)
  ) u_kseg_addr_map (
    .i_vaddr (mem_addr_i),
    .o_paddr (w_paddr)
  );

  // The first request cycle comes straight from the MEM stage; later cycles replay the latched copy.
  always_comb begin
    data_req_o   = 1'b0;
    stallreq_o   = 1'b0;
    data_wr_o    = r_wr;
    data_size_o  = r_size;
    data_wstrb_o = r_wstrb;
    data_addr_o  = r_addr;
    data_wdata_o = r_wdata;
    case (r_state)
      ST_IDLE: begin
        data_req_o   = w_start;
        stallreq_o   = w_start;
        data_wr_o    = w_start ? mem_we_i    : 1'b0;
        data_size_o  = w_start ? mem_size_i  : 2'd0;
        data_wstrb_o = w_start ? mem_sel_i   : 4'd0;
        data_addr_o  = w_start ? w_paddr     : '0;
        data_wdata_o = w_start ? mem_wdata_i : '0;
      end
      ST_ADDR: begin
        data_req_o = 1'b1;
        stallreq_o = 1'b1;
      end
      ST_DATA: begin
        stallreq_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_rdata_o = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_wr    <= mem_we_i;
            r_size  <= mem_size_i;
            r_wstrb <= mem_sel_i;
            r_addr  <= w_paddr;
            r_wdata <= mem_wdata_i;
            r_drop  <= 1'b0;
            r_state <= data_addr_ok_i ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (flush_i)        r_drop  <= 1'b1;
          if (data_addr_ok_i) r_state <= ST_DATA;
        end
        ST_DATA: begin
          // A flushed access still has to drain its data_ok, but its result is discarded.
          if (data_data_ok_i) begin
            if (!w_drop_now && !r_wr) r_rdata <= data_rdata_i;
            r_drop  <= 1'b0;
            r_state <= w_drop_now ? ST_IDLE : ST_DONE;
          end else if (flush_i) begin
            r_drop <= 1'b1;
          end
        end
        ST_DONE: begin
          if (flush_i || !other_stall_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: hand-driven bus handshakes, hand-computed expectations.
module tb_dmem_sram_bridge;
  import dmem_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_i, mem_we_i, mem_except_i, flush_i, other_stall_i;
  logic [3:0]  mem_sel_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_o, data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32), .MAP_KSEG(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_en_i       (mem_en_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_size_i     (mem_size_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_except_i   (mem_except_i),
    .flush_i        (flush_i),
    .other_stall_i  (other_stall_i),
    .mem_rdata_o    (mem_rdata_o),
    .stallreq_o     (stallreq_o),
    .data_req_o     (data_req_o),
    .data_wr_o      (data_wr_o),
    .data_size_o    (data_size_o),
    .data_wstrb_o   (data_wstrb_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_addr_ok_i (data_addr_ok_i),
    .data_data_ok_i (data_data_ok_i),
    .data_rdata_i   (data_rdata_i)
  );

  always #5 clk = ~clk;

  // Accepted requests are counted at the edge where req and addr_ok coincide.
  always @(posedge clk) if (rst && data_req_o && data_addr_ok_i) n_acc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_en_i = 0; mem_we_i = 0; mem_sel_i = 4'h0; mem_size_i = 2'd0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_except_i = 0; flush_i = 0;
    other_stall_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 32'h0;
  endtask

  task automatic load(input logic [31:0] a);
    mem_en_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_size_i = SIZE_WORD; mem_addr_i = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   64'(data_req_o), 64'd0);
    chk({tag, "_stall"}, 64'(stallreq_o), 64'd0);
    chk({tag, "_bus"},   64'({data_wr_o, data_size_o, data_wstrb_o}), 64'd0);
    chk({tag, "_addr"},  64'(data_addr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(data_wdata_o), 64'd0);
    chk({tag, "_rdata"}, 64'(mem_rdata_o), 64'd0);
    chk({tag, "_state"}, 64'(dut.r_state), 64'(ST_IDLE));
  endtask

  initial begin
    rst = 0;
    idle_in();
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1;

    // 1: word load from kseg0, minimum latency
    tick(); load(32'h8000_0100); data_addr_ok_i = 1;
    #2; chk("t1_req_c0", 64'(data_req_o), 64'd1);
    chk("t1_addr", 64'(data_addr_o), 64'h0000_0100);
    chk("t1_stall_c0", 64'(stallreq_o), 64'd1);
    tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'hDEAD_BEEF;
    #2; chk("t1_req_c1", 64'(data_req_o), 64'd0);
    chk("t1_stall_c1", 64'(stallreq_o), 64'd1);
    tick(); data_data_ok_i = 0; data_rdata_i = 32'h0;
    #2; chk("t1_stall_c2", 64'(stallreq_o), 64'd0);
    chk("t1_rdata_c2", 64'(mem_rdata_o), 64'hDEAD_BEEF);
    tick(); idle_in();
    #2; chk("t1_idle_req", 64'(data_req_o), 64'd0);
    chk("t1_rdata_held", 64'(mem_rdata_o), 64'hDEAD_BEEF);
    chk("t1_acc", 64'(n_acc), 64'd1);

    // 2: byte store, addr_ok three cycles late
    tick(); mem_en_i = 1; mem_we_i = 1; mem_sel_i = 4'b0100; mem_size_i = SIZE_BYTE;
    mem_addr_i = 32'h0000_0206; mem_wdata_i = 32'h00AB_0000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_addr_ok_i = 1;
      #2; chk($sformatf("t2_req_c%0d", i), 64'(data_req_o), 64'd1);
      chk($sformatf("t2_stall_c%0d", i), 64'(stallreq_o), 64'd1);
      chk($sformatf("t2_fields_c%0d", i), 64'({data_wr_o, data_size_o, data_wstrb_o}), 64'b1_00_0100);
      chk($sformatf("t2_addr_c%0d", i), 64'(data_addr_o), 64'h0000_0206);
      chk($sformatf("t2_wdata_c%0d", i), 64'(data_wdata_o), 64'h00AB_0000);
      tick();
      mem_wdata_i = 32'hFFFF_FFFF;
      data_data_ok_i = (i == 1);
      data_rdata_i = 32'h7777_7777;
    end
    data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'h1234_5678;
    #2; chk("t2_data_req", 64'(data_req_o), 64'd0);
    chk("t2_data_stall", 64'(stallreq_o), 64'd1);
    tick(); data_data_ok_i = 0;
    #2; chk("t2_done_stall", 64'(stallreq_o), 64'd0);
    chk("t2_store_rdata", 64'(mem_rdata_o), 64'hDEAD_BEEF);
    chk("t2_acc", 64'(n_acc), 64'd2);
    tick(); idle_in();

    // 3: load completes under a long external stall
    tick(); load(32'h0000_0010); data_addr_ok_i = 1; other_stall_i = 1;
    #2; chk("t3_req_c0", 64'(data_req_o), 64'd1);
    tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'hCAFE_F00D;
    tick(); data_data_ok_i = 0; data_rdata_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      #2; chk($sformatf("t3_state_%0d", i), 64'(dut.r_state), 64'(ST_DONE));
      chk($sformatf("t3_req_%0d", i), 64'(data_req_o), 64'd0);
      chk($sformatf("t3_stall_%0d", i), 64'(stallreq_o), 64'd0);
      chk($sformatf("t3_rdata_%0d", i), 64'(mem_rdata_o), 64'hCAFE_F00D);
      tick();
    end
    other_stall_i = 0;
    #2; chk("t3_still_done", 64'(dut.r_state), 64'(ST_DONE));
    tick(); idle_in();
    #2; chk("t3_idle", 64'(dut.r_state), 64'(ST_IDLE));
    chk("t3_acc", 64'(n_acc), 64'd3);

    // 4: flush while waiting for data
    tick(); load(32'h0000_0020); data_addr_ok_i = 1;
    tick(); data_addr_ok_i = 0; flush_i = 1;
    #2; chk("t4_stall_flush", 64'(stallreq_o), 64'd1);
    chk("t4_req_flush", 64'(data_req_o), 64'd0);
    tick(); flush_i = 0; mem_en_i = 0;
    #2; chk("t4_stall_wait", 64'(stallreq_o), 64'd1);
    tick(); data_data_ok_i = 1; data_rdata_i = 32'h5555_5555;
    #2; chk("t4_stall_dok", 64'(stallreq_o), 64'd1);
    tick(); idle_in();
    #2; chk("t4_state", 64'(dut.r_state), 64'(ST_IDLE));
    chk("t4_stall_after", 64'(stallreq_o), 64'd0);
    chk("t4_rdata_kept", 64'(mem_rdata_o), 64'hCAFE_F00D);
    chk("t4_acc", 64'(n_acc), 64'd4);

    // 5: excepting or flushed instruction in IDLE never reaches the bus
    tick(); load(32'h0000_0003); mem_except_i = 1; data_addr_ok_i = 1;
    #2; chk("t5_exc_req", 64'(data_req_o), 64'd0);
    chk("t5_exc_stall", 64'(stallreq_o), 64'd0);
    tick(); mem_except_i = 0; flush_i = 1;
    #2; chk("t5_fl_req", 64'(data_req_o), 64'd0);
    chk("t5_fl_stall", 64'(stallreq_o), 64'd0);
    tick(); idle_in();
    #2; chk("t5_state", 64'(dut.r_state), 64'(ST_IDLE));
    chk("t5_acc", 64'(n_acc), 64'd4);

    // 6: back-to-back loads, kseg1 then unmapped
    tick(); load(32'hA000_0000); data_addr_ok_i = 1;
    #2; chk("t6_addr_a", 64'(data_addr_o), 64'h0000_0000);
    tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'h1111_1111;
    tick(); data_data_ok_i = 0;
    #2; chk("t6_rdata_a", 64'(mem_rdata_o), 64'h1111_1111);
    tick(); load(32'h1FC0_0000); data_addr_ok_i = 1;
    #2; chk("t6_req_b", 64'(data_req_o), 64'd1);
    chk("t6_addr_b", 64'(data_addr_o), 64'h1FC0_0000);
    tick(); data_addr_ok_i = 0; data_data_ok_i = 1; data_rdata_i = 32'h2222_2222;
    tick(); data_data_ok_i = 0;
    #2; chk("t6_rdata_b", 64'(mem_rdata_o), 64'h2222_2222);
    chk("t6_acc", 64'(n_acc), 64'd6);
    tick(); idle_in();

    // 7: asynchronous reset in the middle of the address phase
    tick(); load(32'h0000_0040);
    tick();
    #2; chk("t7_in_addr", 64'(dut.r_state), 64'(ST_ADDR));
    chk("t7_req_addr", 64'(data_req_o), 64'd1);
    idle_in();
    rst = 0;
    #1; chk_all_zero("t7");
    @(negedge clk);
    rst = 1;
    tick();
    #2; chk("t7_acc", 64'(n_acc), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
